arp_rx: RTL and testbench
=========================

Name: arp_rx

Overview:
- Receive-side ARP parser. Consumes the ARP payload stream that the MAC/eth-type demux delivers on a 64-bit AXI-Stream, 6 beats per frame.
- Checks the fixed ARP header fields and the target protocol address against the local IP.
- Reports each valid sender MAC/IP pair to the ARP transmitter and ARP table, and requests a reply when an ARP request for the local IP arrives.

Parameters:
- P_SRC_IP_ADDR, {8'd192,8'd168,8'd100,8'd99}: local IP used after reset.
- P_DROP_CNT_W, 16: width of the saturating dropped-frame counter.

Ports:
- i_clk, input, 1: clock. Reset is i_rst, asynchronous, active-high; clock is i_clk.
- i_rst, input, 1: asynchronous active-high reset.
- i_dymanic_src_ip, input, 32: new local IP.
- i_src_ip_valid, input, 1: load i_dymanic_src_ip into the local-IP register.
- s_axis_arp_data, input, 64: payload beat, big-endian, first octet in [63:56].
- s_axis_arp_user, input, 80: {len16, src_mac48, ethertype16} from the MAC layer.
- s_axis_arp_keep, input, 8: byte enables.
- s_axis_arp_last, input, 1: last beat of the frame.
- s_axis_arp_valid, input, 1: beat valid. There is no ready; the block always accepts.
- o_recv_target_mac, output, 48: sender hardware address (SHA) of the last accepted frame.
- o_recv_target_ip, output, 32: sender protocol address (SPA) of the last accepted frame.
- o_recv_target_valid, output, 1: 1-cycle pulse; the MAC/IP outputs are valid in this cycle.
- o_arp_reply, output, 1: 1-cycle pulse, coincident with o_recv_target_valid, raised for a request.
- o_arp_oper, output, 16: opcode of the last accepted frame (1 = request, 2 = reply).
- o_drop_cnt, output, P_DROP_CNT_W: count of rejected frames, saturating.

Behaviour:
- Reset values of all outputs are 0; the local-IP register resets to P_SRC_IP_ADDR. i_src_ip_valid has priority over holding and takes effect on the next clock edge.
- Beat layout, one beat per cycle:
  - b0 = {htype16, ptype16, hlen8, plen8, oper16}
  - b1 = {sha48, spa[31:16]}
  - b2 = {spa[15:0], tha48}
  - b3 = {tpa32, pad32}
  - b4 and b5 are padding and are ignored.
- Beat counter r_beat (3 bits) advances on each valid beat, saturates at 4, and returns to 0 on a valid beat with last.
  - The first valid beat after reset or after a last is b0.
  - A reset mid-frame makes the next valid beat b0. The header check then normally fails and the frame counts as a drop.
- Field capture: sha, spa, tpa and oper are captured into internal registers as their beats arrive. Outputs are updated only on acceptance.
- Error flag r_err is cleared at b0 and is set by any of the following:
  - b0: htype != 1, ptype != 16'h0800, hlen != 6, plen != 4, or oper not in {1,2}.
  - b0: s_axis_arp_user[15:0] != 16'h0806.
  - keep != 8'hff on b0–b2, or keep[7:4] != 4'hf on b3.
  - last asserted on b0–b2 (truncated frame).
  - tpa != local IP at b3.
- Decision happens at the b3 beat, using b3 data and the r_err value including b0–b2 errors.
  - Pass: on the next cycle o_recv_target_mac/ip and o_arp_oper are loaded, and o_recv_target_valid pulses for 1 cycle.
  - If oper == 1, o_arp_reply pulses in the same cycle.
  - Latency is 1 cycle from the b3 beat to the pulse, independent of the remaining padding beats and of last.
- Fail: no pulse, the outputs hold their values, and o_drop_cnt increments by 1 (saturating at all ones). Only one increment occurs per frame, either at b3 or at a truncating last.
- Beats after b3 are ignored until last.
- A last on b3 itself is legal; a frame with fewer than 6 beats but at least 4 is accepted.
- If i_src_ip_valid occurs in the same cycle as b3, tpa is compared against the old local IP.
- Back-to-back frames with no idle cycle are supported. Gaps (valid low) inside a frame are allowed; the counter holds.

Test Plan:
- Request for the local IP: b0 = 0001_0800_0604_0001, sha = 0A0B0C0D0E0F, spa = C0A86401, tpa = C0A86463, ethertype 0806.
  -> 1 cycle after b3: o_recv_target_valid = 1 and o_arp_reply = 1, mac = 0A0B0C0D0E0F, ip = C0A86401, oper = 1, drop_cnt = 0.
- Same frame with oper = 2 -> valid pulse, no o_arp_reply, oper = 2.
- tpa = C0A86464 -> no pulse, outputs unchanged, drop_cnt = 1.
- last asserted on b2 -> drop_cnt increments once. The following good frame, sent back-to-back, is accepted.
- i_src_ip_valid with C0A80A0A, then a request to C0A80A0A -> o_arp_reply pulses. A request to C0A86463 is dropped.
- Reset asserted at b2 of a good frame -> outputs 0. Remaining beats cause one drop. The next full frame is accepted normally.

Source files
------------

// File: rtl/arp_rx.sv
// Receive-side ARP parser: validates the fixed header and target IP of each 6-beat
// ARP payload, reports the sender MAC/IP and flags requests that need a reply.
module arp_rx #(
  parameter logic [31:0] P_SRC_IP_ADDR = {8'd192, 8'd168, 8'd100, 8'd99},
  parameter int unsigned P_DROP_CNT_W  = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [31:0]             i_dymanic_src_ip,
  input  logic                    i_src_ip_valid,
  input  logic [63:0]             s_axis_arp_data,
  input  logic [79:0]             s_axis_arp_user,
  input  logic [7:0]              s_axis_arp_keep,
  input  logic                    s_axis_arp_last,
  input  logic                    s_axis_arp_valid,
  output logic [47:0]             o_recv_target_mac,
  output logic [31:0]             o_recv_target_ip,
  output logic                    o_recv_target_valid,
  output logic                    o_arp_reply,
  output logic [15:0]             o_arp_oper,
  output logic [P_DROP_CNT_W-1:0] o_drop_cnt
);

  localparam logic [2:0] BeatHdr = 3'd0;
  localparam logic [2:0] BeatSha = 3'd1;
  localparam logic [2:0] BeatTha = 3'd2;
  localparam logic [2:0] BeatTpa = 3'd3;
  localparam logic [2:0] BeatPad = 3'd4;
  localparam logic [P_DROP_CNT_W-1:0] DropOne = 1;

  logic [2:0]              beat_q, beat_d;
  logic                    err_q, err_d;
  logic [47:0]             sha_q, sha_d;
  logic [31:0]             spa_q, spa_d;
  logic [15:0]             oper_q, oper_d;
  logic [31:0]             local_ip_q, local_ip_d;
  logic [47:0]             mac_q, mac_d;
  logic [31:0]             ip_q, ip_d;
  logic [15:0]             oper_out_q, oper_out_d;
  logic                    valid_q, valid_d;
  logic                    reply_q, reply_d;
  logic [P_DROP_CNT_W-1:0] drop_q, drop_d;

  logic hdr_err, beat_err, drop_inc;

  // Only the ethertype of the sideband is relevant here.
  logic unused_user;
  assign unused_user = ^s_axis_arp_user[79:16];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      beat_q     <= BeatHdr;
      err_q      <= 1'b0;
      sha_q      <= '0;
      spa_q      <= '0;
      oper_q     <= '0;
      local_ip_q <= P_SRC_IP_ADDR;
      mac_q      <= '0;
      ip_q       <= '0;
      oper_out_q <= '0;
      valid_q    <= 1'b0;
      reply_q    <= 1'b0;
      drop_q     <= '0;
    end else begin
      beat_q     <= beat_d;
      err_q      <= err_d;
      sha_q      <= sha_d;
      spa_q      <= spa_d;
      oper_q     <= oper_d;
      local_ip_q <= local_ip_d;
      mac_q      <= mac_d;
      ip_q       <= ip_d;
      oper_out_q <= oper_out_d;
      valid_q    <= valid_d;
      reply_q    <= reply_d;
      drop_q     <= drop_d;
    end
  end

  // Per-beat error terms for the beat currently on the bus.
  always_comb begin
    hdr_err = (s_axis_arp_data[63:48] != 16'h0001) ||
              (s_axis_arp_data[47:32] != 16'h0800) ||
              (s_axis_arp_data[31:24] != 8'd6)     ||
              (s_axis_arp_data[23:16] != 8'd4)     ||
              !((s_axis_arp_data[15:0] == 16'd1) || (s_axis_arp_data[15:0] == 16'd2)) ||
              (s_axis_arp_user[15:0] != 16'h0806);
    beat_err = 1'b0;
    unique case (beat_q)
      BeatHdr:          beat_err = hdr_err || (s_axis_arp_keep != 8'hff) || s_axis_arp_last;
      BeatSha, BeatTha: beat_err = (s_axis_arp_keep != 8'hff) || s_axis_arp_last;
      // Compared against the registered IP, so a same-cycle load sees the old value.
      BeatTpa:          beat_err = (s_axis_arp_keep[7:4] != 4'hf) ||
                                   (s_axis_arp_data[63:32] != local_ip_q);
      default:          beat_err = 1'b0;
    endcase
  end

  always_comb begin
    beat_d     = beat_q;
    err_d      = err_q;
    sha_d      = sha_q;
    spa_d      = spa_q;
    oper_d     = oper_q;
    local_ip_d = i_src_ip_valid ? i_dymanic_src_ip : local_ip_q;
    mac_d      = mac_q;
    ip_d       = ip_q;
    oper_out_d = oper_out_q;
    valid_d    = 1'b0;
    reply_d    = 1'b0;
    drop_inc   = 1'b0;

    if (s_axis_arp_valid) begin
      if (s_axis_arp_last) begin
        beat_d = BeatHdr;
      end else if (beat_q < BeatPad) begin
        beat_d = beat_q + 3'd1;
      end

      unique case (beat_q)
        BeatHdr: begin
          err_d  = beat_err;
          oper_d = s_axis_arp_data[15:0];
        end
        BeatSha: begin
          err_d         = err_q | beat_err;
          sha_d         = s_axis_arp_data[63:16];
          spa_d[31:16]  = s_axis_arp_data[15:0];
        end
        BeatTha: begin
          err_d        = err_q | beat_err;
          spa_d[15:0]  = s_axis_arp_data[63:48];
        end
        BeatTpa: begin
          err_d = err_q | beat_err;
          if (err_q || beat_err) begin
            drop_inc = 1'b1;
          end else begin
            mac_d      = sha_q;
            ip_d       = spa_q;
            oper_out_d = oper_q;
            valid_d    = 1'b1;
            reply_d    = (oper_q == 16'd1);
          end
        end
        default: ;
      endcase

      // Truncated frame: the b3 decision never happens, so drop here instead.
      if (s_axis_arp_last && (beat_q < BeatTpa)) begin
        drop_inc = 1'b1;
      end
    end

    drop_d = (drop_inc && (drop_q != '1)) ? drop_q + DropOne : drop_q;
  end

  always_comb begin
    o_recv_target_mac   = mac_q;
    o_recv_target_ip    = ip_q;
    o_recv_target_valid = valid_q;
    o_arp_reply         = reply_q;
    o_arp_oper          = oper_out_q;
    o_drop_cnt          = drop_q;
  end

endmodule

// File: tb/tb_arp_rx.sv
// Self-checking bench for arp_rx: directed scenarios plus randomized frames checked
// against a frame-level reference model.
module tb_arp_rx;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [31:0] i_dymanic_src_ip;
  logic        i_src_ip_valid;
  logic [63:0] s_axis_arp_data;
  logic [79:0] s_axis_arp_user;
  logic [7:0]  s_axis_arp_keep;
  logic        s_axis_arp_last;
  logic        s_axis_arp_valid;
  logic [47:0] o_recv_target_mac;
  logic [31:0] o_recv_target_ip;
  logic        o_recv_target_valid;
  logic        o_arp_reply;
  logic [15:0] o_arp_oper;
  logic [15:0] o_drop_cnt;

  arp_rx dut (
    .i_clk               (i_clk),
    .i_rst               (i_rst),
    .i_dymanic_src_ip    (i_dymanic_src_ip),
    .i_src_ip_valid      (i_src_ip_valid),
    .s_axis_arp_data     (s_axis_arp_data),
    .s_axis_arp_user     (s_axis_arp_user),
    .s_axis_arp_keep     (s_axis_arp_keep),
    .s_axis_arp_last     (s_axis_arp_last),
    .s_axis_arp_valid    (s_axis_arp_valid),
    .o_recv_target_mac   (o_recv_target_mac),
    .o_recv_target_ip    (o_recv_target_ip),
    .o_recv_target_valid (o_recv_target_valid),
    .o_arp_reply         (o_arp_reply),
    .o_arp_oper          (o_arp_oper),
    .o_drop_cnt          (o_drop_cnt)
  );

  always #5 i_clk = ~i_clk;

  localparam logic [31:0] DefIp = 32'hC0A86463;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int b3_cyc = 0;

  // Observed pulses
  int pulse_cnt = 0;
  int reply_cnt = 0;
  int stray_cnt = 0;
  int p_cyc = 0;

  // Expected state
  logic [47:0] e_mac;
  logic [31:0] e_ip;
  logic [15:0] e_oper;
  logic [15:0] e_drop;
  int          e_pulses = 0;
  int          e_replies = 0;
  logic [31:0] m_ip = DefIp;

  // Frame under construction
  logic [63:0] f_data [8];
  logic [7:0]  f_keep [8];
  logic [79:0] f_user;

  always @(posedge i_clk) cyc <= cyc + 1;

  always @(negedge i_clk) begin
    if (o_recv_target_valid) begin
      pulse_cnt <= pulse_cnt + 1;
      p_cyc     <= cyc;
      if (o_arp_reply) reply_cnt <= reply_cnt + 1;
    end else if (o_arp_reply) begin
      stray_cnt <= stray_cnt + 1;
    end
  end

  function automatic logic [111:0] cur_obs();
    return {o_recv_target_mac, o_recv_target_ip, o_arp_oper, o_drop_cnt};
  endfunction

  function automatic logic [111:0] exp_obs();
    return {e_mac, e_ip, e_oper, e_drop};
  endfunction

  task automatic build(input logic [15:0] oper, input logic [47:0] sha, input logic [31:0] spa,
                       input logic [31:0] tpa, input logic [15:0] etype);
    logic [47:0] tha;
    tha = {$urandom, 16'($urandom)};
    f_data[0] = {16'h0001, 16'h0800, 8'd6, 8'd4, oper};
    f_data[1] = {sha, spa[31:16]};
    f_data[2] = {spa[15:0], tha};
    f_data[3] = {tpa, $urandom};
    for (int i = 4; i < 8; i++) f_data[i] = {$urandom, $urandom};
    for (int i = 0; i < 3; i++) f_keep[i] = 8'hff;
    f_keep[3] = {4'hf, 4'($urandom)};
    for (int i = 4; i < 8; i++) f_keep[i] = 8'($urandom);
    f_user = {16'd46, $urandom, 16'($urandom), etype};
  endtask

  // Frame-level reference: accepted iff at least 4 beats and every field rule holds.
  function automatic bit model_accept(input int n, input logic [31:0] ip);
    bit ok;
    logic [15:0] op;
    op = f_data[0][15:0];
    ok = (n >= 4);
    ok = ok && f_data[0][63:48] == 16'h0001 && f_data[0][47:32] == 16'h0800;
    ok = ok && f_data[0][31:24] == 8'd6 && f_data[0][23:16] == 8'd4;
    ok = ok && (op == 16'd1 || op == 16'd2) && f_user[15:0] == 16'h0806;
    for (int i = 0; i < 3; i++) ok = ok && (f_keep[i] == 8'hff);
    ok = ok && (f_keep[3][7:4] == 4'hf) && (f_data[3][63:32] == ip);
    return ok;
  endfunction

  task automatic apply_model(input int n, output bit acc);
    acc = model_accept(n, m_ip);
    if (acc) begin
      e_mac  = f_data[1][63:16];
      e_ip   = {f_data[1][15:0], f_data[2][63:48]};
      e_oper = f_data[0][15:0];
      e_pulses++;
      if (e_oper == 16'd1) e_replies++;
    end else if (n > 0 && e_drop != 16'hffff) begin
      e_drop++;
    end
  endtask

  task automatic send_frame(input int n, input bit gaps, input bit ld, input logic [31:0] ld_ip);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        int g;
        g = $urandom_range(0, 2);
        repeat (g) begin
          @(negedge i_clk);
          s_axis_arp_valid = 1'b0;
          s_axis_arp_last  = 1'b0;
          i_src_ip_valid   = 1'b0;
        end
      end
      @(negedge i_clk);
      s_axis_arp_data  = f_data[i];
      s_axis_arp_keep  = f_keep[i];
      s_axis_arp_user  = f_user;
      s_axis_arp_last  = (i == n - 1);
      s_axis_arp_valid = 1'b1;
      i_src_ip_valid   = ld && (i == 3);
      i_dymanic_src_ip = ld_ip;
      if (i == 3) b3_cyc = cyc;
    end
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(negedge i_clk);
      s_axis_arp_valid = 1'b0;
      s_axis_arp_last  = 1'b0;
      i_src_ip_valid   = 1'b0;
    end
    #1;
  endtask

  task automatic load_ip(input logic [31:0] ip);
    @(negedge i_clk);
    i_src_ip_valid   = 1'b1;
    i_dymanic_src_ip = ip;
    @(negedge i_clk);
    i_src_ip_valid   = 1'b0;
    m_ip = ip;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    repeat (3) @(negedge i_clk);
    checks++;
    if (cur_obs() !== 112'd0 || o_recv_target_valid !== 1'b0 || o_arp_reply !== 1'b0) begin
      errors++;
      $display("FAIL reset_in got %h exp 0", cur_obs());
    end
    i_rst = 1'b0;
    e_mac = '0; e_ip = '0; e_oper = '0; e_drop = '0;
    idle(2);
    checks++;
    if (cur_obs() !== exp_obs() || pulse_cnt !== 0) begin
      errors++;
      $display("FAIL reset_out got %h pulses %0d exp %h pulses 0", cur_obs(), pulse_cnt, exp_obs());
    end
  endtask

  task automatic test_request();
    bit acc;
    build(16'd1, 48'h0A0B0C0D0E0F, 32'hC0A86401, 32'hC0A86463, 16'h0806);
    apply_model(6, acc);
    send_frame(6, 1'b0, 1'b0, 32'h0);
    idle(3);
    checks++;
    if (cur_obs() !== {48'h0A0B0C0D0E0F, 32'hC0A86401, 16'd1, 16'd0}) begin
      errors++;
      $display("FAIL request_outputs got %h exp %h", cur_obs(),
               {48'h0A0B0C0D0E0F, 32'hC0A86401, 16'd1, 16'd0});
    end
    checks++;
    if (pulse_cnt !== e_pulses || reply_cnt !== e_replies) begin
      errors++;
      $display("FAIL request_pulse got %0d/%0d exp %0d/%0d", pulse_cnt, reply_cnt, e_pulses, e_replies);
    end
    checks++;
    if (p_cyc !== b3_cyc + 1) begin
      errors++;
      $display("FAIL request_latency got %0d exp %0d", p_cyc, b3_cyc + 1);
    end
  endtask

  task automatic test_reply_oper();
    bit acc;
    build(16'd2, 48'h0A0B0C0D0E0F, 32'hC0A86401, 32'hC0A86463, 16'h0806);
    apply_model(6, acc);
    send_frame(6, 1'b0, 1'b0, 32'h0);
    idle(3);
    checks++;
    if (cur_obs() !== exp_obs() || o_arp_oper !== 16'd2) begin
      errors++;
      $display("FAIL reply_outputs got %h exp %h", cur_obs(), exp_obs());
    end
    checks++;
    if (pulse_cnt !== e_pulses || reply_cnt !== e_replies) begin
      errors++;
      $display("FAIL reply_pulse got %0d/%0d exp %0d/%0d", pulse_cnt, reply_cnt, e_pulses, e_replies);
    end
  endtask

  task automatic test_wrong_tpa();
    bit acc;
    build(16'd1, 48'h112233445566, 32'hC0A86402, 32'hC0A86464, 16'h0806);
    apply_model(6, acc);
    send_frame(6, 1'b0, 1'b0, 32'h0);
    idle(3);
    checks++;
    if (cur_obs() !== exp_obs() || o_drop_cnt !== 16'd1) begin
      errors++;
      $display("FAIL wrong_tpa got %h exp %h", cur_obs(), exp_obs());
    end
    checks++;
    if (pulse_cnt !== e_pulses) begin
      errors++;
      $display("FAIL wrong_tpa_pulse got %0d exp %0d", pulse_cnt, e_pulses);
    end
  endtask

  task automatic test_truncated();
    bit acc;
    build(16'd1, 48'h665544332211, 32'hC0A86403, 32'hC0A86463, 16'h0806);
    apply_model(3, acc);
    send_frame(3, 1'b0, 1'b0, 32'h0);
    build(16'd1, 48'h0C0C0C0C0C0C, 32'hC0A86404, 32'hC0A86463, 16'h0806);
    apply_model(6, acc);
    send_frame(6, 1'b0, 1'b0, 32'h0);
    idle(3);
    checks++;
    if (cur_obs() !== exp_obs() || o_drop_cnt !== 16'd2) begin
      errors++;
      $display("FAIL truncated_b2b got %h exp %h", cur_obs(), exp_obs());
    end
    checks++;
    if (pulse_cnt !== e_pulses || p_cyc !== b3_cyc + 1) begin
      errors++;
      $display("FAIL truncated_b2b_pulse got %0d@%0d exp %0d@%0d", pulse_cnt, p_cyc, e_pulses,
               b3_cyc + 1);
    end
    // Last on b3 is a complete frame.
    build(16'd2, 48'h0D0D0D0D0D0D, 32'hC0A86405, 32'hC0A86463, 16'h0806);
    apply_model(4, acc);
    send_frame(4, 1'b0, 1'b0, 32'h0);
    idle(3);
    checks++;
    if (cur_obs() !== exp_obs() || pulse_cnt !== e_pulses) begin
      errors++;
      $display("FAIL last_on_b3 got %h/%0d exp %h/%0d", cur_obs(), pulse_cnt, exp_obs(), e_pulses);
    end
  endtask

  task automatic test_dynamic_ip();
    bit acc;
    load_ip(32'hC0A80A0A);
    build(16'd1, 48'h0E0E0E0E0E0E, 32'hC0A80A01, 32'hC0A80A0A, 16'h0806);
    apply_model(6, acc);
    send_frame(6, 1'b1, 1'b0, 32'h0);
    idle(3);
    checks++;
    if (cur_obs() !== exp_obs() || reply_cnt !== e_replies) begin
      errors++;
      $display("FAIL dyn_ip_new got %h/%0d exp %h/%0d", cur_obs(), reply_cnt, exp_obs(), e_replies);
    end
    build(16'd1, 48'h0F0F0F0F0F0F, 32'hC0A80A02, 32'hC0A86463, 16'h0806);
    apply_model(6, acc);
    send_frame(6, 1'b0, 1'b0, 32'h0);
    idle(3);
    checks++;
    if (cur_obs() !== exp_obs() || pulse_cnt !== e_pulses) begin
      errors++;
      $display("FAIL dyn_ip_old got %h/%0d exp %h/%0d", cur_obs(), pulse_cnt, exp_obs(), e_pulses);
    end
    // Load coincident with b3: the old IP still decides this frame.
    build(16'd1, 48'h010203040506, 32'hC0A80B01, 32'hC0A80B0B, 16'h0806);
    apply_model(6, acc);
    send_frame(6, 1'b0, 1'b1, 32'hC0A80B0B);
    m_ip = 32'hC0A80B0B;
    idle(3);
    checks++;
    if (cur_obs() !== exp_obs() || pulse_cnt !== e_pulses) begin
      errors++;
      $display("FAIL dyn_ip_same_cycle got %h/%0d exp %h/%0d", cur_obs(), pulse_cnt, exp_obs(),
               e_pulses);
    end
    build(16'd1, 48'h0A0A0A0A0A0A, 32'hC0A80B02, 32'hC0A80B0B, 16'h0806);
    apply_model(6, acc);
    send_frame(6, 1'b0, 1'b0, 32'h0);
    idle(3);
    checks++;
    if (cur_obs() !== exp_obs() || pulse_cnt !== e_pulses) begin
      errors++;
      $display("FAIL dyn_ip_after got %h/%0d exp %h/%0d", cur_obs(), pulse_cnt, exp_obs(), e_pulses);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit acc;
    int pulses_before;
    build(16'd1, 48'h0B0B0B0B0B0B, 32'hC0A86406, m_ip, 16'h0806);
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      s_axis_arp_data  = f_data[i];
      s_axis_arp_keep  = f_keep[i];
      s_axis_arp_user  = f_user;
      s_axis_arp_last  = 1'b0;
      s_axis_arp_valid = 1'b1;
      if (i == 2) i_rst = 1'b1;
    end
    @(posedge i_clk);
    #1;
    checks++;
    if (cur_obs() !== 112'd0) begin
      errors++;
      $display("FAIL mid_reset_outputs got %h exp 0", cur_obs());
    end
    pulses_before = pulse_cnt;
    for (int i = 3; i < 6; i++) begin
      @(negedge i_clk);
      i_rst = 1'b0;
      s_axis_arp_data  = f_data[i];
      s_axis_arp_keep  = f_keep[i];
      s_axis_arp_last  = (i == 5);
      s_axis_arp_valid = 1'b1;
    end
    idle(3);
    e_mac = '0; e_ip = '0; e_oper = '0; e_drop = 16'd1;
    m_ip = DefIp;
    checks++;
    if (cur_obs() !== exp_obs() || pulse_cnt !== pulses_before) begin
      errors++;
      $display("FAIL mid_reset_tail got %h/%0d exp %h/%0d", cur_obs(), pulse_cnt, exp_obs(),
               pulses_before);
    end
    e_pulses = pulse_cnt;
    e_replies = reply_cnt;
    build(16'd1, 48'h123456789ABC, 32'hC0A86407, DefIp, 16'h0806);
    apply_model(6, acc);
    send_frame(6, 1'b0, 1'b0, 32'h0);
    idle(3);
    checks++;
    if (cur_obs() !== exp_obs() || pulse_cnt !== e_pulses || reply_cnt !== e_replies) begin
      errors++;
      $display("FAIL mid_reset_next got %h/%0d exp %h/%0d", cur_obs(), pulse_cnt, exp_obs(),
               e_pulses);
    end
  endtask

  task automatic test_random();
    bit acc;
    int n, kind, kb;
    logic [15:0] op;
    for (int t = 0; t < 60; t++) begin
      op = ($urandom_range(0, 1) == 0) ? 16'd1 : 16'd2;
      build(op, {$urandom, 16'($urandom)}, $urandom, m_ip, 16'h0806);
      kind = $urandom_range(0, 11);
      unique case (kind)
        0: f_data[0][63:48] = 16'h0006;
        1: f_data[0][47:32] = 16'h86DD;
        2: f_data[0][31:16] = 16'h0604 ^ 16'(1 << $urandom_range(0, 15));
        3: f_data[0][15:0]  = ($urandom_range(0, 1) == 0) ? 16'd0 : 16'($urandom_range(3, 65535));
        4: f_user[15:0]     = 16'h0800;
        5: begin
          kb = $urandom_range(0, 3);
          if (kb == 3) f_keep[3][7:4] = 4'($urandom_range(0, 14));
          else f_keep[kb] = 8'($urandom_range(0, 254));
        end
        6: f_data[3][63:32] = m_ip ^ (32'd1 << $urandom_range(0, 31));
        default: ;
      endcase
      n = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 6;
      apply_model(n, acc);
      send_frame(n, 1'($urandom_range(0, 1)), 1'b0, 32'h0);
      idle(2);
      checks++;
      if (cur_obs() !== exp_obs()) begin
        errors++;
        $display("FAIL rand_%0d_outputs kind %0d n %0d got %h exp %h", t, kind, n, cur_obs(),
                 exp_obs());
      end
      checks++;
      if (pulse_cnt !== e_pulses || reply_cnt !== e_replies) begin
        errors++;
        $display("FAIL rand_%0d_pulses got %0d/%0d exp %0d/%0d", t, pulse_cnt, reply_cnt,
                 e_pulses, e_replies);
      end
      if (acc) begin
        checks++;
        if (p_cyc !== b3_cyc + 1) begin
          errors++;
          $display("FAIL rand_%0d_latency got %0d exp %0d", t, p_cyc, b3_cyc + 1);
        end
      end
    end
  endtask

  initial begin
    i_rst = 1'b1;
    i_dymanic_src_ip = '0;
    i_src_ip_valid = 1'b0;
    s_axis_arp_data = '0;
    s_axis_arp_user = '0;
    s_axis_arp_keep = '0;
    s_axis_arp_last = 1'b0;
    s_axis_arp_valid = 1'b0;
    test_reset();
    test_request();
    test_reply_oper();
    test_wrong_tpa();
    test_truncated();
    test_dynamic_ip();
    test_reset_mid_frame();
    test_random();
    checks++;
    if (stray_cnt !== 0) begin
      errors++;
      $display("FAIL stray_reply got %0d exp 0", stray_cnt);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
